serv_bus_arbiter: RTL and testbench

//  Shares one memory port between the SERV core's instruction bus and data bus.

---
 rtl/serv_arb_pkg.sv | 15 +
 rtl/serv_arb_watchdog.sv | 38 +++
 rtl/serv_bus_arbiter.sv | 176 +++++++++++++++++
 tb/tb_serv_bus_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serv_arb_pkg.sv
// Shared types and constants for the SERV instruction/data bus arbiter.
package serv_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    ACK   = 2'd3
  } arb_state_t;

  localparam logic       GNT_IBUS = 1'b0;
  localparam logic       GNT_DBUS = 1'b1;
  localparam logic [3:0] IBUS_SEL = 4'hF;

endpackage

// File: rtl/serv_arb_watchdog.sv
// Grant watchdog: counts cycles spent waiting on the memory and flags expiry
// once TIMEOUT_CYCLES-1 is reached while enabled.
module serv_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign o_expire = i_en && (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en && !o_expire) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serv_bus_arbiter.sv
// Arbitrates the SERV ibus and dbus onto one registered memory port.
// Optional grant watchdog enabled by defining SERV_ARB_TIMEOUT_EN.
module serv_bus_arbiter
  import serv_arb_pkg::*;
#(
  parameter int ADR_W          = 16,
  parameter int ARB_RR         = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic [ADR_W-1:0] i_ibus_adr,
  input  logic             i_ibus_cyc,
  output logic [31:0]      o_ibus_rdt,
  output logic             o_ibus_ack,
  input  logic [ADR_W-1:0] i_dbus_adr,
  input  logic [31:0]      i_dbus_dat,
  input  logic [3:0]       i_dbus_sel,
  input  logic             i_dbus_we,
  input  logic             i_dbus_cyc,
  output logic [31:0]      o_dbus_rdt,
  output logic             o_dbus_ack,
  output logic [ADR_W-1:0] o_mem_adr,
  output logic [31:0]      o_mem_dat,
  output logic [3:0]       o_mem_sel,
  output logic             o_mem_we,
  output logic             o_mem_cyc,
  input  logic [31:0]      i_mem_rdt,
  input  logic             i_mem_ack,
  output logic             o_timeout
);

  arb_state_t       state_q,    state_d;
  logic             last_gnt_q, last_gnt_d;
  logic [ADR_W-1:0] mem_adr_q,  mem_adr_d;
  logic [31:0]      mem_dat_q,  mem_dat_d;
  logic [3:0]       mem_sel_q,  mem_sel_d;
  logic             mem_we_q,   mem_we_d;
  logic             mem_cyc_q,  mem_cyc_d;
  logic [31:0]      ibus_rdt_q, ibus_rdt_d;
  logic             ibus_ack_q, ibus_ack_d;
  logic [31:0]      dbus_rdt_q, dbus_rdt_d;
  logic             dbus_ack_q, dbus_ack_d;
  logic             timeout_q,  timeout_d;

  logic pick;
  logic grant;
  logic in_gnt;
  logic wd_expire;
  logic done;

  assign in_gnt = (state_q == GNT_I) || (state_q == GNT_D);

`ifdef SERV_ARB_TIMEOUT_EN
  serv_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .i_rst   (i_rst),
    .i_clr   (grant),
    .i_en    (in_gnt),
    .o_expire(wd_expire)
  );
`else
  assign wd_expire = 1'b0;
`endif

  // A transaction ends on a real memory ack or on watchdog expiry.
  assign done = in_gnt && (i_mem_ack || wd_expire);

  always_comb begin
    if (i_ibus_cyc && i_dbus_cyc) begin
      pick = (ARB_RR != 0) ? ~last_gnt_q : GNT_DBUS;
    end else begin
      pick = i_dbus_cyc ? GNT_DBUS : GNT_IBUS;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    mem_adr_d  = mem_adr_q;
    mem_dat_d  = mem_dat_q;
    mem_sel_d  = mem_sel_q;
    mem_we_d   = mem_we_q;
    mem_cyc_d  = mem_cyc_q;
    ibus_rdt_d = ibus_rdt_q;
    dbus_rdt_d = dbus_rdt_q;
    ibus_ack_d = 1'b0;
    dbus_ack_d = 1'b0;
    timeout_d  = 1'b0;
    grant      = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_ibus_cyc || i_dbus_cyc) begin
          grant      = 1'b1;
          last_gnt_d = pick;
          mem_cyc_d  = 1'b1;
          if (pick == GNT_DBUS) begin
            state_d   = GNT_D;
            mem_adr_d = i_dbus_adr;
            mem_dat_d = i_dbus_dat;
            mem_sel_d = i_dbus_sel;
            mem_we_d  = i_dbus_we;
          end else begin
            state_d   = GNT_I;
            mem_adr_d = i_ibus_adr;
            mem_dat_d = 32'h0;
            mem_sel_d = IBUS_SEL;
            mem_we_d  = 1'b0;
          end
        end
      end
      GNT_I, GNT_D: begin
        if (done) begin
          state_d   = ACK;
          mem_cyc_d = 1'b0;
          timeout_d = !i_mem_ack;
          if (state_q == GNT_I) begin
            ibus_ack_d = 1'b1;
            ibus_rdt_d = i_mem_ack ? i_mem_rdt : 32'h0;
          end else begin
            dbus_ack_d = 1'b1;
            dbus_rdt_d = i_mem_ack ? i_mem_rdt : 32'h0;
          end
        end
      end
      // Never re-arbitrate here: the requester's cyc is still high this cycle.
      ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      last_gnt_q <= GNT_IBUS;
      mem_adr_q  <= '0;
      mem_dat_q  <= 32'h0;
      mem_sel_q  <= 4'h0;
      mem_we_q   <= 1'b0;
      mem_cyc_q  <= 1'b0;
      ibus_rdt_q <= 32'h0;
      ibus_ack_q <= 1'b0;
      dbus_rdt_q <= 32'h0;
      dbus_ack_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      mem_adr_q  <= mem_adr_d;
      mem_dat_q  <= mem_dat_d;
      mem_sel_q  <= mem_sel_d;
      mem_we_q   <= mem_we_d;
      mem_cyc_q  <= mem_cyc_d;
      ibus_rdt_q <= ibus_rdt_d;
      ibus_ack_q <= ibus_ack_d;
      dbus_rdt_q <= dbus_rdt_d;
      dbus_ack_q <= dbus_ack_d;
      timeout_q  <= timeout_d;
    end
  end

  assign o_mem_adr  = mem_adr_q;
  assign o_mem_dat  = mem_dat_q;
  assign o_mem_sel  = mem_sel_q;
  assign o_mem_we   = mem_we_q;
  assign o_mem_cyc  = mem_cyc_q;
  assign o_ibus_rdt = ibus_rdt_q;
  assign o_ibus_ack = ibus_ack_q;
  assign o_dbus_rdt = dbus_rdt_q;
  assign o_dbus_ack = dbus_ack_q;
  assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_serv_bus_arbiter.sv
// Directed bench for serv_bus_arbiter: instance 0 round-robin, instance 1 fixed priority.
module tb_serv_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst      [2];
  logic [15:0] ibus_adr [2];
  logic        ibus_cyc [2];
  logic [31:0] ibus_rdt [2];
  logic        ibus_ack [2];
  logic [15:0] dbus_adr [2];
  logic [31:0] dbus_dat [2];
  logic [3:0]  dbus_sel [2];
  logic        dbus_we  [2];
  logic        dbus_cyc [2];
  logic [31:0] dbus_rdt [2];
  logic        dbus_ack [2];
  logic [15:0] mem_adr  [2];
  logic [31:0] mem_dat  [2];
  logic [3:0]  mem_sel  [2];
  logic        mem_we   [2];
  logic        mem_cyc  [2];
  logic [31:0] mem_rdt  [2];
  logic        mem_ack  [2];
  logic        timeout  [2];

  int tests = 0;
  int fails = 0;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    serv_bus_arbiter #(
      .ADR_W         (16),
      .ARB_RR        ((gi == 0) ? 1 : 0),
      .TIMEOUT_CYCLES(8)
    ) dut (
      .clk       (clk),
      .i_rst     (rst[gi]),
      .i_ibus_adr(ibus_adr[gi]),
      .i_ibus_cyc(ibus_cyc[gi]),
      .o_ibus_rdt(ibus_rdt[gi]),
      .o_ibus_ack(ibus_ack[gi]),
      .i_dbus_adr(dbus_adr[gi]),
      .i_dbus_dat(dbus_dat[gi]),
      .i_dbus_sel(dbus_sel[gi]),
      .i_dbus_we (dbus_we[gi]),
      .i_dbus_cyc(dbus_cyc[gi]),
      .o_dbus_rdt(dbus_rdt[gi]),
      .o_dbus_ack(dbus_ack[gi]),
      .o_mem_adr (mem_adr[gi]),
      .o_mem_dat (mem_dat[gi]),
      .o_mem_sel (mem_sel[gi]),
      .o_mem_we  (mem_we[gi]),
      .o_mem_cyc (mem_cyc[gi]),
      .i_mem_rdt (mem_rdt[gi]),
      .i_mem_ack (mem_ack[gi]),
      .o_timeout (timeout[gi])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("[TB] check %-14s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic do_reset(input int idx);
    rst[idx] = 1'b1;
    tick();
    tick();
    rst[idx] = 1'b0;
  endtask

  // Both request together, winner completes, dbus re-requests in IDLE while ibus waits.
  task automatic arb_pair(input int idx, input logic second_is_d);
    ibus_adr[idx] = 16'h0100;
    dbus_adr[idx] = 16'h0200;
    dbus_dat[idx] = 32'h7777_7777;
    dbus_sel[idx] = 4'hC;
    dbus_we[idx]  = 1'b0;
    ibus_cyc[idx] = 1'b1;
    dbus_cyc[idx] = 1'b1;
    tick();
    check("arb1_adr", 32'(mem_adr[idx]), 32'h0000_0200);
    mem_ack[idx] = 1'b1;
    mem_rdt[idx] = 32'h0000_00A1;
    tick();
    check("arb1_dack", 32'(dbus_ack[idx]), 32'd1);
    check("arb1_iack", 32'(ibus_ack[idx]), 32'd0);
    dbus_cyc[idx] = 1'b0;
    mem_ack[idx]  = 1'b0;
    tick();
    dbus_cyc[idx] = 1'b1;
    tick();
    check("arb2_adr", 32'(mem_adr[idx]), second_is_d ? 32'h0000_0200 : 32'h0000_0100);
    check("arb2_dat", mem_dat[idx], second_is_d ? 32'h7777_7777 : 32'h0);
    check("arb2_sel", 32'(mem_sel[idx]), second_is_d ? 32'hC : 32'hF);
    mem_ack[idx] = 1'b1;
    mem_rdt[idx] = 32'h0000_00B2;
    tick();
    check("arb2_dack", 32'(dbus_ack[idx]), 32'(second_is_d));
    check("arb2_iack", 32'(ibus_ack[idx]), 32'(!second_is_d));
    check("arb2_rdt", second_is_d ? dbus_rdt[idx] : ibus_rdt[idx], 32'h0000_00B2);
    mem_ack[idx] = 1'b0;
    if (second_is_d) dbus_cyc[idx] = 1'b0;
    else             ibus_cyc[idx] = 1'b0;
    tick();
    ibus_cyc[idx] = 1'b0;
    dbus_cyc[idx] = 1'b0;
    tick();
    check("arb_idle_cyc", 32'(mem_cyc[idx]), 32'd0);
  endtask

  task automatic wait_iack(input int idx, input int max, output int n);
    n = 0;
    while (ibus_ack[idx] !== 1'b1 && n < max) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b0; ibus_adr[i] = '0; ibus_cyc[i] = 1'b0;
      dbus_adr[i] = '0; dbus_dat[i] = '0; dbus_sel[i] = '0; dbus_we[i] = 1'b0;
      dbus_cyc[i] = 1'b0; mem_rdt[i] = '0; mem_ack[i] = 1'b0;
    end
    do_reset(0);
    do_reset(1);
    check("rst_cyc", 32'(mem_cyc[0]), 32'd0);
    check("rst_adr", 32'(mem_adr[0]), 32'd0);
    check("rst_acks", {30'd0, ibus_ack[0], dbus_ack[0]}, 32'd0);
    check("rst_timeout", 32'(timeout[0]), 32'd0);

    // ibus only: cyc in cycle 0, mem ack in cycle 2, ibus ack in cycle 3
    ibus_adr[0] = 16'h0100;
    ibus_cyc[0] = 1'b1;
    tick();
    check("i_cyc", 32'(mem_cyc[0]), 32'd1);
    check("i_adr", 32'(mem_adr[0]), 32'h0100);
    check("i_we", 32'(mem_we[0]), 32'd0);
    check("i_sel", 32'(mem_sel[0]), 32'hF);
    tick();
    check("i_ack_early", 32'(ibus_ack[0]), 32'd0);
    mem_ack[0] = 1'b1;
    mem_rdt[0] = 32'h1234_5678;
    tick();
    check("i_ack", 32'(ibus_ack[0]), 32'd1);
    check("i_rdt", ibus_rdt[0], 32'h1234_5678);
    check("i_cyc_drop", 32'(mem_cyc[0]), 32'd0);
    mem_ack[0]  = 1'b0;
    ibus_cyc[0] = 1'b0;
    tick();
    check("i_ack_pulse", 32'(ibus_ack[0]), 32'd0);

    // dbus write with minimum memory latency
    dbus_adr[0] = 16'h2000;
    dbus_dat[0] = 32'hDEAD_BEEF;
    dbus_sel[0] = 4'h3;
    dbus_we[0]  = 1'b1;
    dbus_cyc[0] = 1'b1;
    tick();
    check("d_adr", 32'(mem_adr[0]), 32'h2000);
    check("d_dat", mem_dat[0], 32'hDEAD_BEEF);
    check("d_sel", 32'(mem_sel[0]), 32'h3);
    check("d_we", 32'(mem_we[0]), 32'd1);
    check("d_cyc", 32'(mem_cyc[0]), 32'd1);
    mem_ack[0] = 1'b1;
    mem_rdt[0] = 32'hCAFE_F00D;
    tick();
    check("d_ack", 32'(dbus_ack[0]), 32'd1);
    check("d_rdt", dbus_rdt[0], 32'hCAFE_F00D);
    check("d_i_silent", 32'(ibus_ack[0]), 32'd0);
    check("d_i_rdt_keep", ibus_rdt[0], 32'h1234_5678);
    mem_ack[0]  = 1'b0;
    dbus_cyc[0] = 1'b0;
    tick();
    check("d_ack_pulse", 32'(dbus_ack[0]), 32'd0);

    // reset while in GNT_D, then a late memory ack
    dbus_adr[0] = 16'h2004;
    dbus_cyc[0] = 1'b1;
    tick();
    check("r_gnt_cyc", 32'(mem_cyc[0]), 32'd1);
    rst[0] = 1'b1;
    dbus_cyc[0] = 1'b0;
    tick();
    rst[0] = 1'b0;
    check("r_cyc", 32'(mem_cyc[0]), 32'd0);
    check("r_rdt", dbus_rdt[0], 32'd0);
    mem_ack[0] = 1'b1;
    mem_rdt[0] = 32'h0000_0055;
    tick();
    check("r_late_ack", 32'(dbus_ack[0]), 32'd0);
    tick();
    check("r_late_ack2", 32'(dbus_ack[0]), 32'd0);
    check("r_late_cyc", 32'(mem_cyc[0]), 32'd0);
    mem_ack[0] = 1'b0;

    // arbitration from last_gnt=ibus: round-robin then fixed priority
    arb_pair(0, 1'b0);
    arb_pair(1, 1'b1);

    // stalled memory on ibus
    ibus_adr[0] = 16'h0300;
    ibus_cyc[0] = 1'b1;
    mem_rdt[0]  = 32'hFFFF_FFFF;
`ifdef SERV_ARB_TIMEOUT_EN
    wait_iack(0, 30, n);
    check("to_latency", 32'(n), 32'd9);
    check("to_pulse", 32'(timeout[0]), 32'd1);
    check("to_rdt", ibus_rdt[0], 32'h0);
`else
    repeat (20) tick();
    check("stall_ack", 32'(ibus_ack[0]), 32'd0);
    check("stall_cyc", 32'(mem_cyc[0]), 32'd1);
    check("stall_to", 32'(timeout[0]), 32'd0);
    mem_ack[0] = 1'b1;
    tick();
    mem_ack[0] = 1'b0;
    check("stall_done", 32'(ibus_ack[0]), 32'd1);
    check("stall_rdt", ibus_rdt[0], 32'hFFFF_FFFF);
`endif
    ibus_cyc[0] = 1'b0;
    tick();
    check("to_clear", 32'(timeout[0]), 32'd0);

    // following request is serviced normally
    ibus_adr[0] = 16'h0304;
    ibus_cyc[0] = 1'b1;
    mem_rdt[0]  = 32'h1357_9BDF;
    tick();
    mem_ack[0] = 1'b1;
    wait_iack(0, 10, n);
    check("post_latency", 32'(n), 32'd1);
    check("post_rdt", ibus_rdt[0], 32'h1357_9BDF);
    check("post_to", 32'(timeout[0]), 32'd0);
    mem_ack[0]  = 1'b0;
    ibus_cyc[0] = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
